// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_sb
// Purpose  : Parametrised register file with two registered read ports, one
//            write port, write-to-read bypass, an optional hardwired zero
//            register, and a per-register busy scoreboard for hazard tracking.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            rd_en1/2          - read enables
//            rd_addr1/2        - read addresses
//            rd_data1/2        - registered read data (1-cycle latency)
//            rd_busy1/2        - registered busy flag of the read address
//            wr_en/addr/data   - write port (also clears the busy bit)
//            busy_set/addr     - issue strobe marking a pending write
//            busy_cnt          - number of registers currently busy
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en1,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    output logic              rd_busy1,
    input  logic              rd_en2,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_addr,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0]  r_mem [c_DEPTH];
    logic [c_DEPTH-1:0] r_busy;
    logic [DATA_W-1:0]  r_rd_data1;
    logic [DATA_W-1:0]  r_rd_data2;
    logic               r_rd_busy1;
    logic               r_rd_busy2;
    logic [ADDR_W:0]    r_busy_cnt;

    logic               w_wr_ok;
    logic               w_set_ok;
    logic               w_rd1_zero;
    logic               w_rd2_zero;
    logic [c_DEPTH-1:0] w_busy_next;
    logic [ADDR_W:0]    w_cnt_next;

    // Accesses to register 0 are neutralised when it is hardwired to zero.
    assign w_wr_ok    = wr_en    && !((ZERO_REG != 0) && (wr_addr   == '0));
    assign w_set_ok   = busy_set && !((ZERO_REG != 0) && (busy_addr == '0));
    assign w_rd1_zero = (ZERO_REG != 0) && (rd_addr1 == '0);
    assign w_rd2_zero = (ZERO_REG != 0) && (rd_addr2 == '0);

    // Post-update busy vector: clear by the write first, then the set, so a
    // newly issued producer wins over a retiring one on the same register.
    always_comb begin
        w_busy_next = r_busy;
        if (w_wr_ok) begin
            w_busy_next[wr_addr] = 1'b0;
        end
        if (w_set_ok) begin
            w_busy_next[busy_addr] = 1'b1;
        end
    end

    // Population count of the post-update busy vector.
    always_comb begin
        w_cnt_next = '0;
        for (int i = 0; i < c_DEPTH; i++) begin
            w_cnt_next = w_cnt_next + {{ADDR_W{1'b0}}, w_busy_next[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_busy     <= '0;
            r_busy_cnt <= '0;
            r_rd_data1 <= '0;
            r_rd_data2 <= '0;
            r_rd_busy1 <= 1'b0;
            r_rd_busy2 <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_mem[wr_addr] <= wr_data;
            end
            r_busy     <= w_busy_next;
            r_busy_cnt <= w_cnt_next;

            // Read port 1: bypass the in-flight write so the reader sees the
            // value being committed on this edge.
            if (rd_en1) begin
                if (w_rd1_zero) begin
                    r_rd_data1 <= '0;
                    r_rd_busy1 <= 1'b0;
                end else begin
                    r_rd_data1 <= (w_wr_ok && (wr_addr == rd_addr1)) ? wr_data : r_mem[rd_addr1];
                    r_rd_busy1 <= w_busy_next[rd_addr1];
                end
            end

            // Read port 2: identical behaviour, independent address.
            if (rd_en2) begin
                if (w_rd2_zero) begin
                    r_rd_data2 <= '0;
                    r_rd_busy2 <= 1'b0;
                end else begin
                    r_rd_data2 <= (w_wr_ok && (wr_addr == rd_addr2)) ? wr_data : r_mem[rd_addr2];
                    r_rd_busy2 <= w_busy_next[rd_addr2];
                end
            end
        end
    end

    assign rd_data1 = r_rd_data1;
    assign rd_data2 = r_rd_data2;
    assign rd_busy1 = r_rd_busy1;
    assign rd_busy2 = r_rd_busy2;
    assign busy_cnt = r_busy_cnt;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_sb
// Purpose  : Directed self-checking bench for reg_file_sb (32x32, zero reg on).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;

    localparam int c_DW = 32;
    localparam int c_AW = 5;

    logic            clk;
    logic            rst;
    logic            rd_en1;
    logic [c_AW-1:0] rd_addr1;
    logic [c_DW-1:0] rd_data1;
    logic            rd_busy1;
    logic            rd_en2;
    logic [c_AW-1:0] rd_addr2;
    logic [c_DW-1:0] rd_data2;
    logic            rd_busy2;
    logic            wr_en;
    logic [c_AW-1:0] wr_addr;
    logic [c_DW-1:0] wr_data;
    logic            busy_set;
    logic [c_AW-1:0] busy_addr;
    logic [c_AW:0]   busy_cnt;

    int n_checks = 0;
    int n_err    = 0;

    reg_file_sb #(
        .DATA_W   (c_DW),
        .ADDR_W   (c_AW),
        .ZERO_REG (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_en1    (rd_en1),
        .rd_addr1  (rd_addr1),
        .rd_data1  (rd_data1),
        .rd_busy1  (rd_busy1),
        .rd_en2    (rd_en2),
        .rd_addr2  (rd_addr2),
        .rd_data2  (rd_data2),
        .rd_busy2  (rd_busy2),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy_set  (busy_set),
        .busy_addr (busy_addr),
        .busy_cnt  (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, landing 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        rd_en1 = 1'b0; rd_addr1 = '0;
        rd_en2 = 1'b0; rd_addr2 = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        busy_set = 1'b0; busy_addr = '0;

        // Reset state, observed before any clock edge
        #2;
        check("rst_data1", rd_data1, 0);
        check("rst_busy1", rd_busy1, 0);
        check("rst_cnt", busy_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset then read r7
        rd_en1 = 1'b1; rd_addr1 = 5'd7;
        tick();
        check("r7_data", rd_data1, 0);
        check("r7_busy", rd_busy1, 0);
        check("r7_cnt", busy_cnt, 0);

        // Write r5, read it the next edge, then hold with rd_en1=0
        rd_en1 = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        tick();
        wr_en = 1'b0;
        rd_en1 = 1'b1; rd_addr1 = 5'd5;
        tick();
        check("r5_read", rd_data1, 32'hDEADBEEF);
        rd_en1 = 1'b0; rd_addr1 = 5'd7;
        tick();
        check("r5_hold", rd_data1, 32'hDEADBEEF);

        // Bypass on both ports
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h11111111;
        tick();
        wr_data = 32'h22222222;
        rd_en1 = 1'b1; rd_addr1 = 5'd9;
        rd_en2 = 1'b1; rd_addr2 = 5'd9;
        tick();
        check("byp_p1", rd_data1, 32'h22222222);
        check("byp_p2", rd_data2, 32'h22222222);
        wr_en = 1'b0;
        tick();
        check("r9_stored", rd_data2, 32'h22222222);

        // Zero register: write and busy_set on r0 are ignored
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        busy_set = 1'b1; busy_addr = 5'd0;
        rd_addr1 = 5'd0; rd_addr2 = 5'd0;
        tick();
        check("z_data1", rd_data1, 0);
        check("z_data2", rd_data2, 0);
        check("z_busy1", rd_busy1, 0);
        check("z_cnt", busy_cnt, 0);
        wr_en = 1'b0; busy_set = 1'b0;
        tick();
        check("z_after", rd_data1, 0);
        check("z_cnt2", busy_cnt, 0);

        // Scoreboard: set r3
        busy_set = 1'b1; busy_addr = 5'd3;
        rd_addr1 = 5'd3;
        tick();
        check("sb_cnt1", busy_cnt, 1);
        check("sb_busy3", rd_busy1, 1);

        // Set and write r3 on the same edge: set wins, data bypassed
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
        tick();
        check("sb_setwin", rd_busy1, 1);
        check("sb_setwin_cnt", busy_cnt, 1);
        check("sb_byp3", rd_data1, 32'h33);

        // Write r3 alone clears it
        busy_set = 1'b0;
        wr_data = 32'h34;
        tick();
        check("sb_clr_busy", rd_busy1, 0);
        check("sb_clr_cnt", busy_cnt, 0);
        wr_en = 1'b0;

        // Clear of a non-busy register has no effect
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h12;
        tick();
        check("sb_clr_idle", busy_cnt, 0);
        wr_en = 1'b0;

        // Set r3, then r4, then r3 again (already busy)
        busy_set = 1'b1; busy_addr = 5'd3;
        tick();
        busy_addr = 5'd4;
        rd_addr2 = 5'd4;
        tick();
        check("sb_cnt2", busy_cnt, 2);
        check("sb_busy4", rd_busy2, 1);
        busy_addr = 5'd3;
        tick();
        check("sb_reset_dup", busy_cnt, 2);

        // Build r2 = 5A5A5A5A with three busy registers (r3, r4, r5)
        busy_addr = 5'd5;
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h5A5A5A5A;
        tick();
        check("pre_cnt3", busy_cnt, 3);
        busy_set = 1'b0; wr_en = 1'b0;
        rd_addr1 = 5'd2; rd_addr2 = 5'd5;
        tick();
        check("pre_r2", rd_data1, 32'h5A5A5A5A);
        check("pre_busy5", rd_busy2, 1);

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        check("ar_data1", rd_data1, 0);
        check("ar_busy2", rd_busy2, 0);
        check("ar_cnt", busy_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("ar_r2", rd_data1, 0);
        check("ar_r5_busy", rd_busy2, 0);
        check("ar_cnt_after", busy_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised register file with 2 read ports and 1 write port, plus a per-register busy scoreboard.
- Next-generation replacement for the fixed 32x32 register file in the datapath. Sits between decode (read/issue) and writeback (write).
- Adds configurable width and depth, optional hardwired zero register, registered reads with write-to-read bypass, and pending-write tracking for hazard detection.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes, and is never busy; 0 = register 0 is ordinary.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- rd_en1  in  1  read enable, port 1.
- rd_addr1  in  ADDR_W  read address, port 1.
- rd_data1  out  DATA_W  registered read data, port 1.
- rd_busy1  out  1  registered busy flag of rd_addr1.
- rd_en2  in  1  read enable, port 2.
- rd_addr2  in  ADDR_W  read address, port 2.
- rd_data2  out  DATA_W  registered read data, port 2.
- rd_busy2  out  1  registered busy flag of rd_addr2.
- wr_en  in  1  write enable.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- busy_set  in  1  issue strobe: mark busy_addr as pending write.
- busy_addr  in  ADDR_W  register to mark busy.
- busy_cnt  out  ADDR_W+1  number of registers currently busy.

Behaviour:
- Reset (rst=1, asynchronous, takes effect immediately regardless of clk):
  - all DEPTH registers = 0; all busy bits = 0.
  - rd_data1/2 = 0, rd_busy1/2 = 0, busy_cnt = 0.
  - While rst is high, all inputs are ignored. The first active edge is the first rising clk after rst falls.
- Write: on a rising edge with wr_en=1, REG[wr_addr] <= wr_data.
  - If ZERO_REG=1 and wr_addr=0, the write is discarded.
- Read: on a rising edge with rd_enN=1, rd_dataN updates. Latency 1 cycle: the address presented in cycle t gives data valid after edge t.
  - With rd_enN=0, rd_dataN and rd_busyN hold their values.
- Bypass: if the same edge also has wr_en=1 and wr_addr=rd_addrN (and the write is not discarded), rd_dataN <= wr_data (new value), not the old contents.
- Zero register: ZERO_REG=1 and rd_addrN=0 gives rd_dataN <= 0 and rd_busyN <= 0 always.
- Both read ports are independent. The same address on both ports returns identical data.
- Scoreboard, one busy bit per register, updated each rising edge:
  - busy_set=1 sets busy[busy_addr]; ignored for address 0 when ZERO_REG=1.
  - wr_en=1 clears busy[wr_addr].
  - Simultaneous set and clear of the same address: set wins, so the bit is 1 (a new producer was issued).
  - Set of an already-busy register: the bit stays 1 and busy_cnt does not change.
  - Clear of a non-busy register: no effect.
- rd_busyN <= post-update busy value of rd_addrN. It is consistent with the bypass: a write clearing the register on the same edge yields 0, unless busy_set hits the same address on that edge.
- busy_cnt: registered population count of busy bits after the update.
  - Net change per edge is within {-1, 0, +1}.
  - Range 0..DEPTH; width ADDR_W+1 so the value DEPTH is representable.
- Reset mid-operation: an in-flight read or write on the edge coincident with rst assertion is lost. All outputs go to reset values without waiting for a clock.
- No X propagation: the register array is initialised only by reset, and no output depends on an unreset element.

Test Plan:
- Reset then read: rst pulse, rd_en1=1, rd_addr1=7 -> after next edge rd_data1=0, rd_busy1=0, busy_cnt=0.
- Write/read latency: write 0xDEADBEEF to r5 at edge t, read r5 at edge t+1 -> rd_data1=0xDEADBEEF after t+1; rd_en1=0 at t+2 -> rd_data1 holds.
- Bypass: r9 holds 0x11111111; same edge wr_en to r9 with 0x22222222 and rd_addr1=rd_addr2=9 -> both ports =0x22222222.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to r0 and busy_set r0 -> reads of r0 give 0, rd_busy=0, busy_cnt unchanged.
- Scoreboard:
  - set r3 -> busy_cnt=1, read r3 busy=1.
  - Same edge: busy_set r3 and write r3 -> busy stays 1, busy_cnt=1.
  - Write r3 alone -> busy 0, busy_cnt=0.
  - Set r3 and r4 on consecutive edges -> busy_cnt=2.
- Async reset mid-operation: with r2=0x5A5A5A5A and busy_cnt=3, assert rst between edges -> outputs 0 immediately. After release, read r2 -> 0 and busy_cnt=0.
